// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver.
// Raw pins are synchronised, the clock line is glitch filtered, and frames
// (start, 8 data LSB first, odd parity, stop) are decoded into a
// first-word-fall-through receive FIFO. Full-FIFO policy is selectable.
// Parity, framing and overflow problems are reported by sticky flags.
// Optional idle-frame watchdog: define PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2     = 3,
  parameter int FILTER_LEN     = 4,
  parameter int OVERWRITE      = 0,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic                rd_en,
  output logic [7:0]          data,
  output logic                ready,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                parity_err,
  output logic                frame_err,
  input  logic                err_clr,
  output logic                timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [3:0]            FILT_TOP = 4'(FILTER_LEN - 1);

  // Synchronisers and filter
  logic [1:0] clk_sync_reg;
  logic [1:0] data_sync_reg;
  logic       filt_reg;
  logic [3:0] filt_cnt_reg;
  logic       strobe_reg;
  logic       data_s;

  // Frame decoder
  logic [3:0] bit_idx_reg, bit_idx_next;
  logic [8:0] shift_reg, shift_next;
  logic       push;
  logic       parity_bad;
  logic       stop_bad;
  logic       tmo_hit;

  // FIFO
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   level_reg, level_next;
  logic                  wr_en;
  logic                  pop;
  logic                  ovf_set;

  // Sticky flags: {frame_err, parity_err, overflow}
  logic [2:0] flag_reg;
  logic [2:0] flag_set;

  assign data_s = data_sync_reg[1];

  // Two-flop synchronisers; idle-high so reset release creates no edge
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  // Filtered clock follows the synchronised clock only after FILTER_LEN
  // stable cycles; a 1->0 change of the filtered clock raises strobe
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      filt_reg     <= 1'b1;
      filt_cnt_reg <= 4'd0;
      strobe_reg   <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      if (clk_sync_reg[1] == filt_reg) begin
        filt_cnt_reg <= 4'd0;
      end else if (filt_cnt_reg == FILT_TOP) begin
        filt_reg     <= clk_sync_reg[1];
        filt_cnt_reg <= 4'd0;
        strobe_reg   <= filt_reg;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 4'd1;
      end
    end
  end

  // Frame decode: bad start bits are ignored so noise cannot misalign
  // framing; at the stop bit the frame is accepted or flagged
  always_comb begin
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    push         = 1'b0;
    parity_bad   = 1'b0;
    stop_bad     = 1'b0;
    if (strobe_reg) begin
      if (bit_idx_reg == 4'd0) begin
        if (!data_s) begin
          bit_idx_next = 4'd1;
        end
      end else if (bit_idx_reg == 4'd10) begin
        bit_idx_next = 4'd0;
        if (!data_s) begin
          stop_bad = 1'b1;
        end else if (^shift_reg) begin
          push = 1'b1;
        end else begin
          parity_bad = 1'b1;
        end
      end else begin
        shift_next   = {data_s, shift_reg[8:1]};
        bit_idx_next = bit_idx_reg + 4'd1;
      end
    end
    if (tmo_hit) begin
      bit_idx_next = 4'd0;
    end
  end

  // Frame decoder state
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bit_idx_reg <= 4'd0;
      shift_reg   <= 9'd0;
    end else begin
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_TOP = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             tmo_pulse_reg;

  // Abort on the TIMEOUT_CYCLES-th idle cycle inside a frame
  assign tmo_hit = (bit_idx_reg != 4'd0) && !strobe_reg && (tmo_cnt_reg == TMO_TOP);
  assign timeout = tmo_pulse_reg;

  // Idle-frame watchdog: restarts on every strobe, idle outside a frame
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tmo_cnt_reg   <= '0;
      tmo_pulse_reg <= 1'b0;
    end else begin
      tmo_pulse_reg <= tmo_hit;
      if (strobe_reg || (bit_idx_reg == 4'd0) || tmo_hit) begin
        tmo_cnt_reg <= '0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + TMO_ONE;
      end
    end
  end
`else
  // Watchdog not built: a stalled frame simply waits for more clocks
  assign tmo_hit = 1'b0;
  assign timeout = (TIMEOUT_CYCLES > 0) ? 1'b0 : 1'b0;
`endif

  // FIFO control: simultaneous push and pop keeps the level, even when full
  always_comb begin
    pop         = rd_en && (level_reg != '0);
    wr_en       = 1'b0;
    ovf_set     = 1'b0;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (push) begin
      if (pop) begin
        wr_en       = 1'b1;
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end else if (level_reg != LVL_FULL) begin
        wr_en       = 1'b1;
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
        level_next  = level_reg + LVL_ONE;
      end else if (OVERWRITE != 0) begin
        wr_en       = 1'b1;
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
        ovf_set     = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
      level_next  = level_reg - LVL_ONE;
    end
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  // FIFO storage; contents are invalidated by the pointer reset alone
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= shift_reg[7:0];
    end
  end

  assign flag_set = {stop_bad | tmo_hit, parity_bad, ovf_set};

  // Sticky error flags; a set event beats err_clr in the same cycle
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      flag_reg <= 3'b000;
    end else begin
      flag_reg <= flag_set | (flag_reg & ~{3{err_clr}});
    end
  end

  assign ready      = (level_reg != '0);
  assign data       = ready ? mem[rd_ptr_reg] : 8'h00;
  assign level      = level_reg;
  assign overflow   = flag_reg[0];
  assign parity_err = flag_reg[1];
  assign frame_err  = flag_reg[2];

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with glitch filtering, configurable-depth receive FIFO, selectable overflow policy and sticky error reporting. It sits between the board PS/2 pins and the keyboard/mouse decode logic. It is the successor to the fixed 8-entry keyboard receiver. It adds clock-line filtering, start-bit resynchronisation, parity/framing error flags, a fill-level output and an optional frame timeout.

## Interface
- `DEPTH_LOG2`, 3, FIFO depth = 2^DEPTH_LOG2 entries (1..6)
- `FILTER_LEN`, 4, consecutive stable cycles required before filtered ps2_clk changes (2..15)
- `OVERWRITE`, 0, full-FIFO policy: 0 = drop new byte, 1 = drop oldest byte
- `TIMEOUT_CYCLES`, 50000, idle clk cycles mid-frame before abort (used only with macro)
- `clk` in 1: single system clock, all logic on posedge
- `clr` in 1: asynchronous, active-high reset
- `ps2_clk` in 1: raw PS/2 clock pin
- `ps2_data` in 1: raw PS/2 data pin
- `rd_en` in 1: pop strobe; one byte consumed per cycle high while `ready`
- `data` out 8: head-of-FIFO scan byte (first-word-fall-through)
- `ready` out 1: FIFO non-empty
- `level` out DEPTH_LOG2+1: number of stored bytes, 0..2^DEPTH_LOG2
- `overflow` out 1: sticky, a byte was lost to a full FIFO
- `parity_err` out 1: sticky, a frame failed odd parity
- `frame_err` out 1: sticky, bad stop bit or timeout abort
- `err_clr` in 1: clears the three sticky flags
- `timeout` out 1: one-cycle pulse on frame abort (constant 0 without macro)

## Operation
- `ps2_clk` and `ps2_data` each pass through 2-flop synchronisers reset to 1. Filtered clock takes the synchronised value only after it has been stable for FILTER_LEN cycles. A falling edge of the filtered clock produces a one-cycle `strobe`. The synchronised `ps2_data` is sampled on `strobe`.
- Frame = start(0), 8 data bits LSB first, odd parity, stop(1). A bit index 0..10 tracks position.
- Index 0 with sampled 1 (bad start) is ignored and the index stays 0. This resynchronises after noise.
- At index 10: if stop=1 and ^{data,parity}=1, push the byte. If parity fails, set `parity_err` with no push. If stop=0, set `frame_err` with no push; parity is not checked. The index returns to 0 in every case.
- FIFO: circular buffer with rd/wr pointers of DEPTH_LOG2 bits that wrap modulo depth, plus `level`.
- Push when not full: write at wr_ptr, wr_ptr+1, level+1.
- Push when full, OVERWRITE=0: byte discarded, `overflow` set.
- Push when full, OVERWRITE=1: byte written, both pointers advance, level unchanged, `overflow` set.
- Pop when `ready`: rd_ptr+1, level-1. `rd_en` while empty is ignored.
- Simultaneous push and pop with level>0: both take effect, level unchanged, no overflow even when full.
- Simultaneous push and pop with level=0: push only.
- `data` = mem[rd_ptr] when `ready`, else 8'h00.
- `err_clr` clears the sticky flags. A flag set event in the same cycle wins.
- `clr` mid-frame discards the partial frame and all FIFO contents.

## Timing
- Reset values: `data`=8'h00, `ready`=0, `level`=0, `overflow`=`parity_err`=`frame_err`=`timeout`=0. Bit index=0. Synchronisers and filtered clock=1, so no false edge is generated on reset release.
- `strobe` asserts 2+FILTER_LEN cycles after a clean `ps2_clk` fall.
- Byte visible on `data`/`ready`/`level` on the clock edge following the stop-bit `strobe` cycle, i.e. 1 cycle latency.
- Pop: `rd_en` sampled at an edge; `data`, `level` and `ready` update at that same edge.
- Sticky flags assert on the edge after the offending `strobe`, concurrent with where a push would appear.
- Timeout (macro on): counter resets on each `strobe` and counts while index≠0. When the count reaches TIMEOUT_CYCLES: index←0, `frame_err`←1, `timeout` high for exactly one cycle.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined: idle-frame watchdog compiled in as in Timing.
- Not defined: no watchdog counter is built and `timeout` is tied 0. A stalled partial frame waits indefinitely and completes with subsequent clocks.

## Test plan
- Clean frame 0x1C (parity 0) -> `ready`=1, `data`=0x1C, `level`=1. One-cycle `rd_en` -> `ready`=0, `data`=0x00, `level`=0.
- Frame 0x1C with parity bit 1 -> no push, `level`=0, `parity_err`=1. Pulse `err_clr` -> `parity_err`=0.
- Defaults, 9 frames 0x01..0x09 with no reads -> `level`=8, `overflow`=1.
  - OVERWRITE=0: reads return 0x01..0x08.
  - OVERWRITE=1: reads return 0x02..0x09.
- Mid-frame `ps2_clk` low glitch of FILTER_LEN-1 cycles, frame 0xF0 -> no extra strobe, 0xF0 received, no error flags.
- Macro on, TIMEOUT_CYCLES=100: 5 bits then clock idle -> `timeout` pulses once after 100 cycles and `frame_err`=1. Following full frame 0x5A is received correctly.
- FIFO full (level 8), `rd_en` high in the push cycle of frame 0x33 -> `level` stays 8, `overflow`=0, 0x33 read last.
